// File: rtl/ecc_pmul_dual_sched.sv
// ecc_pmul_dual_sched
//   Sequencer for the two curve_mul_256 point-multiplication cores (A and B).
//   It launches the selected core(s) with a one-cycle ena pulse and checks that
//   every launched core acknowledges by dropping rdy. It then waits for rdy to
//   rise again and reports done/status/cycle count to the register block.
//   Run/ack timeouts and abort are enforced. The scope trigger is driven while
//   the cores run.
//
// Optional feature macro: ECC_SCHED_CYCLE_COUNT_EN
//   defined   : O_cycles counts busy cycles (saturating, 32-bit)
//   undefined : no counter logic, O_cycles tied to 0
//
// Ports
//   crypto_clk   clock shared with the cores
//   reset_i      asynchronous active-high reset (does not reset the cores)
//   I_start      start request, honoured only when idle
//   I_mode       00 A, 01 B, 10 A+B together, 11 A then B
//   I_abort      level; abandons the current operation
//   I_timeout    run-cycle limit per operation, 0 = unlimited
//   I_rdy_a/b    core rdy (high = idle/finished)
//   O_ena_a/b    one-cycle core start pulses
//   O_busy       operation in progress
//   O_done       one-cycle completion pulse (success or error)
//   O_status     {timeout, abort, ack_err}, sticky until next accepted start
//   O_trigger    high while the launched core(s) run
//   O_cycles     busy-cycle count of the last/current operation
module ecc_pmul_dual_sched #(
    parameter int pACK_CYCLES = 8,
    parameter int pTO_WIDTH   = 32
) (
    input  logic                 crypto_clk,
    input  logic                 reset_i,
    input  logic                 I_start,
    input  logic [1:0]           I_mode,
    input  logic                 I_abort,
    input  logic [pTO_WIDTH-1:0] I_timeout,
    input  logic                 I_rdy_a,
    input  logic                 I_rdy_b,
    output logic                 O_ena_a,
    output logic                 O_ena_b,
    output logic                 O_busy,
    output logic                 O_done,
    output logic [2:0]           O_status,
    output logic                 O_trigger,
    output logic [31:0]          O_cycles
);

    // ack_cnt only has to hold 0 .. pACK_CYCLES-1
    localparam int ACW = (pACK_CYCLES < 2) ? 1 : $clog2(pACK_CYCLES);
    localparam logic [ACW-1:0] ACK_LAST = ACW'(pACK_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_ACK    = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] M_B   = 2'b01;
    localparam logic [1:0] M_AB  = 2'b10;
    localparam logic [1:0] M_SEQ = 2'b11;

    // status encoding {timeout, abort, ack_err}
    localparam logic [2:0] ST_TO    = 3'b100;
    localparam logic [2:0] ST_ABORT = 3'b010;
    localparam logic [2:0] ST_ACK   = 3'b001;

    logic [2:0]           state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic                 phase_b_q, phase_b_d;   // mode 11: second (B) phase
    logic [2:0]           status_q, status_d;
    logic                 ena_a_q, ena_a_d;
    logic                 ena_b_q, ena_b_d;
    logic [ACW-1:0]       ack_cnt;
    logic [pTO_WIDTH-1:0] run_cnt;

    logic use_a, use_b, all_low, all_high, to_hit, start_ok;

    // Which core(s) the current phase is waiting on
    assign use_a = (mode_q != M_B) && !(mode_q == M_SEQ && phase_b_q);
    assign use_b = (mode_q == M_B) || (mode_q == M_AB) || (mode_q == M_SEQ && phase_b_q);

    assign all_low  = (!use_a || !I_rdy_a) && (!use_b || !I_rdy_b);
    assign all_high = (!use_a ||  I_rdy_a) && (!use_b ||  I_rdy_b);
    assign to_hit   = (I_timeout != '0) && (run_cnt == I_timeout);
    assign start_ok = (state_q == S_IDLE) && I_start;

    // Exit priority inside a phase: completion > abort > timeout > ack_err.
    // An acknowledge seen in the same cycle as abort/timeout does not save it.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        phase_b_d = phase_b_q;
        status_d  = status_q;
        ena_a_d   = 1'b0;
        ena_b_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_start) begin
                    state_d   = S_LAUNCH;
                    mode_d    = I_mode;
                    phase_b_d = 1'b0;
                    status_d  = '0;
                    ena_a_d   = (I_mode != M_B);
                    ena_b_d   = (I_mode == M_B) || (I_mode == M_AB);
                end
            end
            S_LAUNCH: begin
                if (I_abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                if (I_abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else if (to_hit) begin
                    status_d = ST_TO;
                    state_d  = S_DONE;
                end else if (all_low) begin
                    state_d  = S_RUN;
                end else if (ack_cnt == ACK_LAST) begin
                    status_d = ST_ACK;
                    state_d  = S_DONE;
                end
            end
            S_RUN: begin
                if (all_high) begin
                    if (mode_q == M_SEQ && !phase_b_q) begin
                        // A finished: launch B next cycle, run counter keeps going
                        phase_b_d = 1'b1;
                        ena_b_d   = 1'b1;
                        state_d   = S_LAUNCH;
                    end else begin
                        state_d   = S_DONE;
                    end
                end else if (I_abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else if (to_hit) begin
                    status_d = ST_TO;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            phase_b_q <= 1'b0;
            status_q  <= '0;
            ena_a_q   <= 1'b0;
            ena_b_q   <= 1'b0;
            ack_cnt   <= '0;
            run_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            phase_b_q <= phase_b_d;
            status_q  <= status_d;
            ena_a_q   <= ena_a_d;
            ena_b_q   <= ena_b_d;

            if (state_q == S_LAUNCH)
                ack_cnt <= '0;
            else if (state_q == S_ACK)
                ack_cnt <= ack_cnt + ACW'(1);

            if (start_ok)
                run_cnt <= '0;
            else if (state_q == S_ACK || state_q == S_RUN)
                run_cnt <= run_cnt + pTO_WIDTH'(1);
        end
    end

    assign O_busy    = (state_q == S_LAUNCH) || (state_q == S_ACK) || (state_q == S_RUN);
    assign O_done    = (state_q == S_DONE);
    assign O_trigger = (state_q == S_RUN);
    assign O_status  = status_q;
    assign O_ena_a   = ena_a_q;
    assign O_ena_b   = ena_b_q;

`ifdef ECC_SCHED_CYCLE_COUNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i)
            cyc_q <= '0;
        else if (start_ok)
            cyc_q <= '0;
        else if (O_busy && cyc_q != 32'hFFFF_FFFF)
            cyc_q <= cyc_q + 32'd1;
    end

    assign O_cycles = cyc_q;
`else
    assign O_cycles = '0;
`endif

endmodule

// File: tb/tb_ecc_pmul_dual_sched.sv
// Scoreboard bench for ecc_pmul_dual_sched. Behavioural core models answer the
// ena pulses; the reference model predicts each operation's outcome from event
// times (ack, completion, abort, timeout) and a monitor checks every done pulse.
module tb_ecc_pmul_dual_sched;

    localparam int ACK = 8;

    typedef struct {
        int mode;
        int da, ra;     // core A: cycles ena->rdy low (0 = never), low duration
        int db, rb;
        int T;          // I_timeout
        int ab;         // abort cycle relative to the ena cycle, -1 = none
        int sp;         // spurious start cycle relative to ena, -1 = none
    } op_t;

    typedef struct {
        logic [2:0] st;
        int n;          // busy cycles; done appears n cycles after the ena cycle
        int trig;
        int ea, eb;
        int done_cyc;
    } exp_t;

    logic        crypto_clk = 1'b0;
    logic        reset_i;
    logic        I_start, I_abort, I_rdy_a, I_rdy_b;
    logic [1:0]  I_mode;
    logic [31:0] I_timeout;
    logic        O_ena_a, O_ena_b, O_busy, O_done, O_trigger;
    logic [2:0]  O_status;
    logic [31:0] O_cycles;

    int   checks = 0, failures = 0;
    int   cyc = 0, done_cnt = 0;
    int   cur_da, cur_ra, cur_db, cur_rb;
    int   a_ph = 0, a_cnt = 0, b_ph = 0, b_cnt = 0;
    int   na = 0, nb = 0, ntrig = 0;
    exp_t sb[$];
    exp_t mon_ex;

    ecc_pmul_dual_sched #(.pACK_CYCLES(ACK), .pTO_WIDTH(32)) dut (
        .crypto_clk(crypto_clk), .reset_i(reset_i),
        .I_start(I_start), .I_mode(I_mode), .I_abort(I_abort), .I_timeout(I_timeout),
        .I_rdy_a(I_rdy_a), .I_rdy_b(I_rdy_b),
        .O_ena_a(O_ena_a), .O_ena_b(O_ena_b), .O_busy(O_busy), .O_done(O_done),
        .O_status(O_status), .O_trigger(O_trigger), .O_cycles(O_cycles)
    );

    always #5 crypto_clk = ~crypto_clk;
    always @(posedge crypto_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Core models: ena seen in cycle L -> rdy low from cycle L+d for r cycles.
    always @(negedge crypto_clk) begin
        if (O_ena_a) begin a_cnt = 0; a_ph = 1; end
        else if (a_ph == 1) begin
            a_cnt++;
            if (cur_da == 0) a_ph = 0;
            else if (a_cnt == cur_da) begin I_rdy_a = 1'b0; a_ph = 2; a_cnt = 0; end
        end else if (a_ph == 2) begin
            a_cnt++;
            if (a_cnt == cur_ra) begin I_rdy_a = 1'b1; a_ph = 0; end
        end
    end

    always @(negedge crypto_clk) begin
        if (O_ena_b) begin b_cnt = 0; b_ph = 1; end
        else if (b_ph == 1) begin
            b_cnt++;
            if (cur_db == 0) b_ph = 0;
            else if (b_cnt == cur_db) begin I_rdy_b = 1'b0; b_ph = 2; b_cnt = 0; end
        end else if (b_ph == 2) begin
            b_cnt++;
            if (b_cnt == cur_rb) begin I_rdy_b = 1'b1; b_ph = 0; end
        end
    end

    // Reference model for one phase launched at relative cycle t0.
    // kind: 0 complete, 1 abort, 2 timeout, 3 ack error; e = cycle of the exit decision.
    function automatic void ref_phase(input op_t op, input int t0, input bit ua, input bit ub,
                                      input int base, output int e, output int kind, output int trig);
        int big, tack, tc, tab, tto, tfail, tcomp;
        bit ok;
        big = 1 << 30; ok = 1; tack = t0; tc = t0;
        if (ua) begin
            if (op.da == 0 || op.da > ACK) ok = 0;
            else begin
                if (t0 + op.da > tack) tack = t0 + op.da;
                if (t0 + op.da + op.ra > tc) tc = t0 + op.da + op.ra;
            end
        end
        if (ub) begin
            if (op.db == 0 || op.db > ACK) ok = 0;
            else begin
                if (t0 + op.db > tack) tack = t0 + op.db;
                if (t0 + op.db + op.rb > tc) tc = t0 + op.db + op.rb;
            end
        end
        tcomp = ok ? tc : big;
        tfail = ok ? big : t0 + ACK;
        tab   = (op.ab >= t0) ? op.ab : big;
        tto   = (op.T != 0 && op.T >= base) ? t0 + 1 + op.T - base : big;
        e = tcomp; kind = 0;
        if (tab < e)   begin e = tab;   kind = 1; end
        if (tto < e)   begin e = tto;   kind = 2; end
        if (tfail < e) begin e = tfail; kind = 3; end
        trig = (ok && e > tack) ? e - tack : 0;
    endfunction

    function automatic exp_t ref_op(input op_t op);
        exp_t x;
        int e, kind, trig, e2, k2, t2;
        bit ua, ub;
        ua = (op.mode != 1);
        ub = (op.mode == 1 || op.mode == 2);
        x.ea = ua; x.eb = ub;
        ref_phase(op, 0, ua, ub, 0, e, kind, trig);
        x.trig = trig;
        if (kind == 0 && op.mode == 3) begin
            x.eb = 1;
            ref_phase(op, e + 1, 1'b0, 1'b1, e, e2, k2, t2);
            e = e2; kind = k2; x.trig += t2;
        end
        case (kind)
            1:       x.st = 3'b010;
            2:       x.st = 3'b100;
            3:       x.st = 3'b001;
            default: x.st = 3'b000;
        endcase
        x.n = e + 1;
        x.done_cyc = 0;
        return x;
    endfunction

    function automatic op_t mk(input int mode, input int da, input int ra, input int db,
                               input int rb, input int T, input int ab, input int sp);
        op_t o;
        o.mode = mode; o.da = da; o.ra = ra; o.db = db; o.rb = rb;
        o.T = T; o.ab = ab; o.sp = sp;
        return o;
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge crypto_clk) begin
        if (reset_i) begin
            na = 0; nb = 0; ntrig = 0;
        end else begin
            if (O_ena_a) begin chk("ena_a_only_when_busy", O_busy, 1); na++; end
            if (O_ena_b) begin chk("ena_b_only_when_busy", O_busy, 1); nb++; end
            if (O_trigger) ntrig++;
            if (O_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    mon_ex = sb.pop_front();
                    chk("status", O_status, mon_ex.st);
                    chk("done_cycle", cyc, mon_ex.done_cyc);
`ifdef ECC_SCHED_CYCLE_COUNT_EN
                    chk("cycles", O_cycles, mon_ex.n);
`else
                    chk("cycles", O_cycles, 0);
`endif
                    chk("ena_a_count", na, mon_ex.ea);
                    chk("ena_b_count", nb, mon_ex.eb);
                    chk("trigger_cycles", ntrig, mon_ex.trig);
                    chk("busy_at_done", O_busy, 0);
                end
                na = 0; nb = 0; ntrig = 0;
            end
        end
    end

    task automatic wait_cores_idle();
        int k;
        k = 0;
        while (!(I_rdy_a && I_rdy_b && a_ph == 0 && b_ph == 0) && k < 1000) begin
            @(negedge crypto_clk); k++;
        end
        if (k >= 1000) begin
            checks++; failures++;
            $display("FAIL cores_idle_wait actual=busy expected=idle (cycle %0d)", cyc);
        end
    endtask

    task automatic run_op(input op_t op);
        exp_t ex;
        int   dc0, t;
        cur_da = op.da; cur_ra = op.ra; cur_db = op.db; cur_rb = op.rb;
        ex  = ref_op(op);
        dc0 = done_cnt;
        @(negedge crypto_clk);
        I_mode = op.mode[1:0]; I_timeout = op.T; I_start = 1'b1;
        ex.done_cyc = cyc + 1 + ex.n;
        sb.push_back(ex);
        @(negedge crypto_clk);
        I_start = 1'b0;
        t = 0;
        while (done_cnt == dc0 && t < 2000) begin
            I_abort = (t == op.ab);
            I_start = (t == op.sp);
            @(negedge crypto_clk); t++;
        end
        I_abort = 1'b0; I_start = 1'b0;
        if (done_cnt == dc0) begin
            checks++; failures++;
            $display("FAIL done_wait actual=none expected=done (cycle %0d)", cyc);
        end
        wait_cores_idle();
    endtask

    task automatic reset_mid_run();
        int dc0;
        cur_da = 2; cur_ra = 100; cur_db = 2; cur_rb = 100;
        @(negedge crypto_clk);
        I_mode = 2'b00; I_timeout = 0; I_start = 1'b1;
        @(negedge crypto_clk);
        I_start = 1'b0;
        repeat (30) @(negedge crypto_clk);
        reset_i = 1'b1;
        #1;
        chk("midreset_busy", O_busy, 0);
        chk("midreset_trigger", O_trigger, 0);
        chk("midreset_done", O_done, 0);
        chk("midreset_status", O_status, 0);
        chk("midreset_cycles", O_cycles, 0);
        chk("midreset_ena", {O_ena_a, O_ena_b}, 0);
        sb.delete();
        dc0 = done_cnt;
        repeat (2) @(negedge crypto_clk);
        reset_i = 1'b0;
        wait_cores_idle();
        repeat (3) @(negedge crypto_clk);
        chk("no_done_after_reset", done_cnt, dc0);
    endtask

    function automatic int pick_d();
        int r;
        r = $urandom_range(0, 11);
        if (r == 0) return 0;
        if (r == 1) return $urandom_range(ACK + 1, ACK + 4);
        return $urandom_range(1, ACK);
    endfunction

    initial begin
        op_t op;
        reset_i = 1'b1; I_start = 1'b0; I_abort = 1'b0; I_mode = 2'b00; I_timeout = 0;
        I_rdy_a = 1'b1; I_rdy_b = 1'b1;
        cur_da = 1; cur_ra = 10; cur_db = 1; cur_rb = 10;
        repeat (3) @(negedge crypto_clk);
        chk("reset_busy", O_busy, 0);
        chk("reset_done", O_done, 0);
        chk("reset_status", O_status, 0);
        chk("reset_trigger", O_trigger, 0);
        chk("reset_cycles", O_cycles, 0);
        chk("reset_ena", {O_ena_a, O_ena_b}, 0);
        reset_i = 1'b0;
        @(negedge crypto_clk);

        run_op(mk(0, 2, 100, 2, 50, 0, -1, -1));   // A only, 103 busy cycles
        run_op(mk(3, 2, 50, 2, 50, 0, -1, -1));    // A then B
        run_op(mk(2, 2, 50, 0, 50, 0, -1, -1));    // B never acks -> ack_err
        run_op(mk(0, 2, 200, 2, 50, 50, -1, 20));  // timeout, stray start ignored
        run_op(mk(0, 2, 100, 2, 50, 0, 22, -1));   // abort at run cycle 20
        run_op(mk(0, 2, 30, 2, 50, 0, 32, -1));    // abort with rdy rise -> success
        run_op(mk(1, 3, 40, 3, 40, 0, 0, -1));     // abort during LAUNCH
        run_op(mk(1, 3, 40, ACK, 40, 0, -1, -1));  // ack on last allowed cycle
        run_op(mk(0, ACK + 1, 40, 2, 40, 0, -1, -1)); // ack one cycle late
        run_op(mk(3, 2, 30, 4, 30, 40, -1, -1));   // timeout lands in phase B
        reset_mid_run();
        run_op(mk(0, 2, 100, 2, 50, 0, -1, -1));   // clean restart after reset

        for (int i = 0; i < 40; i++) begin
            op.mode = $urandom_range(0, 3);
            op.da = pick_d(); op.ra = $urandom_range(ACK + 2, 60);
            op.db = pick_d(); op.rb = $urandom_range(ACK + 2, 60);
            op.T  = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 150) : 0;
            op.ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 120) : -1;
            op.sp = -1;
            run_op(op);
        end

        repeat (5) @(negedge crypto_clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
